// File: rtl/ga23_tile_fetch.sv
// Tile-row fetch arbiter: collects per-layer row requests and serialises them
// onto a single SDRAM read port using round-robin, returning each row to its layer.
module ga23_tile_fetch #(
  parameter logic [24:0] ROM_BASE   = 25'h0,
  parameter int          NUM_LAYERS = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_LAYERS-1:0]        layer_req,
  input  logic [NUM_LAYERS-1:0][20:0]  layer_addr,
  output logic [NUM_LAYERS-1:0][31:0]  layer_data,
  output logic [NUM_LAYERS-1:0]        layer_rdy,
  output logic [24:0]                  sdr_addr,
  output logic                         sdr_req,
  input  logic                         sdr_rdy,
  input  logic [31:0]                  sdr_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic        pending_reg [NUM_LAYERS];
  logic [20:0] addr_reg    [NUM_LAYERS];
  logic [31:0] data_reg    [NUM_LAYERS];
  logic        rdy_reg     [NUM_LAYERS];
  logic [1:0]  gnt_reg;
  logic        stale_reg;
  logic        sdr_req_reg;
  logic [24:0] sdr_addr_reg;

  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        do_grant;
  logic        do_done;
  logic        deliver;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin scan starting just after the last granted layer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = next_idx(gnt_reg);
    for (int i = 0; i < 3; i++) begin
      if (!grant_valid && pending_reg[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_next = state_reg;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          do_grant   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (sdr_rdy) begin
          do_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A re-request for the in-flight layer, even in the completion cycle, voids the result.
  assign deliver = do_done && !stale_reg && !layer_req[gnt_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 2'd2;
      stale_reg    <= 1'b0;
      sdr_req_reg  <= 1'b0;
      sdr_addr_reg <= 25'h0;
    end else begin
      state_reg <= state_next;
      if (do_grant) begin
        gnt_reg      <= grant_idx;
        sdr_addr_reg <= ROM_BASE + {4'b0000, addr_reg[grant_idx]};
        sdr_req_reg  <= 1'b1;
        stale_reg    <= layer_req[grant_idx];
      end else if (do_done) begin
        sdr_req_reg <= 1'b0;
        stale_reg   <= 1'b0;
      end else if (state_reg == BUSY && layer_req[gnt_reg]) begin
        stale_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      localparam logic [1:0] IDX = 2'(gi);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pending_reg[gi] <= 1'b0;
          addr_reg[gi]    <= 21'h0;
          data_reg[gi]    <= 32'h0;
          rdy_reg[gi]     <= 1'b0;
        end else begin
          rdy_reg[gi] <= 1'b0;
          // A new strobe always wins over the grant clearing the flag.
          if (layer_req[gi]) begin
            pending_reg[gi] <= 1'b1;
            addr_reg[gi]    <= layer_addr[gi];
          end else if (do_grant && grant_idx == IDX) begin
            pending_reg[gi] <= 1'b0;
          end
          if (deliver && gnt_reg == IDX) begin
            data_reg[gi] <= sdr_data;
            rdy_reg[gi]  <= 1'b1;
          end
        end
      end

      assign layer_data[gi] = data_reg[gi];
      assign layer_rdy[gi]  = rdy_reg[gi];
    end
  endgenerate

  assign sdr_req  = sdr_req_reg;
  assign sdr_addr = sdr_addr_reg;

endmodule

// File: tb/tb_ga23_tile_fetch.sv
// Bench for ga23_tile_fetch: directed vector table, hand-written corner sequences,
// and a randomized run against a behavioural model.
module tb_ga23_tile_fetch;

  localparam logic [24:0] BASE = 25'h100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [2:0]       layer_req;
  logic [2:0][20:0] layer_addr;
  logic [2:0][31:0] layer_data;
  logic [2:0]       layer_rdy;
  logic [24:0]      sdr_addr;
  logic             sdr_req;
  logic             sdr_rdy;
  logic [31:0]      sdr_data;

  logic [2:0]       w_req;
  logic [2:0][20:0] w_addr;
  logic [2:0][31:0] w_data;
  logic [2:0]       w_rdy;
  logic [24:0]      w_saddr;
  logic             w_sreq;
  logic             w_srdy;
  logic [31:0]      w_sdata;

  ga23_tile_fetch #(.ROM_BASE(BASE), .NUM_LAYERS(3)) dut (
    .clk(clk), .reset_n(reset_n), .layer_req(layer_req), .layer_addr(layer_addr),
    .layer_data(layer_data), .layer_rdy(layer_rdy), .sdr_addr(sdr_addr),
    .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data)
  );

  ga23_tile_fetch #(.ROM_BASE(25'h1FFFFFC), .NUM_LAYERS(3)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .layer_req(w_req), .layer_addr(w_addr),
    .layer_data(w_data), .layer_rdy(w_rdy), .sdr_addr(w_saddr),
    .sdr_req(w_sreq), .sdr_rdy(w_srdy), .sdr_data(w_sdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [20:0] addr;
    logic        srdy;
    logic [31:0] sdata;
    logic        ereq;
    logic [24:0] eaddr;
    logic [2:0]  erdy;
    logic [31:0] d0, d1, d2;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [2:0] req, input logic [20:0] addr,
                              input logic srdy, input logic [31:0] sdata,
                              input logic ereq, input logic [24:0] eaddr,
                              input logic [2:0] erdy,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2);
    vec_t v;
    v.req = req; v.addr = addr; v.srdy = srdy; v.sdata = sdata;
    v.ereq = ereq; v.eaddr = eaddr; v.erdy = erdy;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    vt.push_back(v);
  endfunction

  // Behavioural model state for the random run
  logic        m_busy, m_stale;
  int          m_g, m_last;
  logic        m_pend [3];
  logic [20:0] m_addr [3];
  logic [31:0] m_data [3];
  logic [24:0] m_exp_addr;
  logic [2:0]  m_rdy;

  task automatic model_edge(input logic [2:0] req, input logic [2:0][20:0] addr,
                            input logic srdy, input logic [31:0] sdata);
    int w;
    m_rdy = 3'b000;
    if (!m_busy) begin
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && m_pend[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (w >= 0) begin
        m_exp_addr = 25'((26'(BASE) + 26'(m_addr[w])) % 26'h2000000);
        m_busy = 1'b1;
        m_g = w;
        m_last = w;
        m_pend[w] = 1'b0;
        m_stale = req[w];
      end
    end else if (srdy) begin
      if (!(m_stale || req[m_g])) begin
        m_data[m_g] = sdata;
        m_rdy[m_g] = 1'b1;
      end
      m_busy = 1'b0;
      m_stale = 1'b0;
    end else if (req[m_g]) begin
      m_stale = 1'b1;
    end
    for (int n = 0; n < 3; n++)
      if (req[n]) begin
        m_pend[n] = 1'b1;
        m_addr[n] = addr[n];
      end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dd;
    int grants [$];
    int pulses, cnt, wcnt;
    logic prev_req, timed_out;
    int cur_g;
    logic [31:0] sent;
    logic [2:0] rq;
    logic [2:0][20:0] ra;
    logic rr;
    logic [31:0] rd;

    reset_n = 1'b0;
    layer_req = '0; layer_addr = '0; sdr_rdy = 1'b0; sdr_data = '0;
    w_req = '0; w_addr = '0; w_srdy = 1'b0; w_sdata = '0;
    tick(); tick();
    chk("reset_sdr_req", sdr_req, 0);
    chk("reset_sdr_addr", sdr_addr, 0);
    chk("reset_layer_rdy", layer_rdy, 0);
    for (int n = 0; n < 3; n++) chk($sformatf("reset_data%0d", n), layer_data[n], 0);
    reset_n = 1'b1;

    dd = 32'hDEADBEEF;
    add(3'b001, 21'h012340, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 25'h112340, 0, 0, 0, 0);
    add(0, 0, 1, dd, 0, 0, 3'b001, dd, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3'b000, dd, 0, 0);
    add(3'b001, 21'h40, 0, 0, 0, 0, 0, dd, 0, 0);
    add(0, 0, 0, 0, 1, 25'h100040, 0, dd, 0, 0);
    add(3'b010, 21'h100, 0, 0, 1, 25'h100040, 0, dd, 0, 0);
    add(3'b010, 21'h200, 0, 0, 1, 25'h100040, 0, dd, 0, 0);
    add(0, 0, 1, 32'h11111111, 0, 0, 3'b001, 32'h11111111, 0, 0);
    add(0, 0, 0, 0, 1, 25'h100200, 0, 32'h11111111, 0, 0);
    add(0, 0, 1, 32'h22222222, 0, 0, 3'b010, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 0);
    add(3'b100, 21'h300, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 0, 0, 1, 25'h100300, 0, 32'h11111111, 32'h22222222, 0);
    add(3'b100, 21'h400, 0, 0, 1, 25'h100300, 0, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 1, 32'h33333333, 0, 0, 3'b000, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 0, 0, 1, 25'h100400, 0, 32'h11111111, 32'h22222222, 0);
    add(0, 0, 1, 32'h44444444, 0, 0, 3'b100, 32'h11111111, 32'h22222222, 32'h44444444);
    add(0, 0, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 32'h44444444);
    add(3'b001, 21'h50, 0, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 32'h44444444);
    add(3'b001, 21'h60, 0, 0, 1, 25'h100050, 0, 32'h11111111, 32'h22222222, 32'h44444444);
    add(0, 0, 1, 32'h55555555, 0, 0, 3'b000, 32'h11111111, 32'h22222222, 32'h44444444);
    add(0, 0, 0, 0, 1, 25'h100060, 0, 32'h11111111, 32'h22222222, 32'h44444444);
    add(0, 0, 1, 32'h66666666, 0, 0, 3'b001, 32'h66666666, 32'h22222222, 32'h44444444);
    add(0, 0, 1, 32'h77777777, 0, 0, 3'b000, 32'h66666666, 32'h22222222, 32'h44444444);
    add(0, 0, 0, 0, 0, 0, 0, 32'h66666666, 32'h22222222, 32'h44444444);

    for (int i = 0; i < vt.size(); i++) begin
      layer_req = vt[i].req;
      layer_addr = {3{vt[i].addr}};
      sdr_rdy = vt[i].srdy;
      sdr_data = vt[i].sdata;
      tick();
      chk($sformatf("vec%0d_sdr_req", i), sdr_req, vt[i].ereq);
      if (vt[i].ereq) chk($sformatf("vec%0d_sdr_addr", i), sdr_addr, vt[i].eaddr);
      chk($sformatf("vec%0d_layer_rdy", i), layer_rdy, vt[i].erdy);
      chk($sformatf("vec%0d_data0", i), layer_data[0], vt[i].d0);
      chk($sformatf("vec%0d_data1", i), layer_data[1], vt[i].d1);
      chk($sformatf("vec%0d_data2", i), layer_data[2], vt[i].d2);
      $display("vec %0d req=%b srdy=%b -> sdr_req=%b sdr_addr=%h rdy=%b",
               i, vt[i].req, vt[i].srdy, sdr_req, sdr_addr, layer_rdy);
    end
    layer_req = '0; sdr_rdy = 1'b0;

    // Reset in the middle of a fetch
    layer_req = 3'b010; layer_addr[1] = 21'h700;
    tick();
    layer_req = '0;
    tick();
    chk("rst_mid_busy_req", sdr_req, 1);
    chk("rst_mid_busy_addr", sdr_addr, 25'h100700);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_sdr_req", sdr_req, 0);
    chk("rst_async_sdr_addr", sdr_addr, 0);
    chk("rst_async_rdy", layer_rdy, 0);
    for (int n = 0; n < 3; n++) chk($sformatf("rst_async_data%0d", n), layer_data[n], 0);
    tick();
    reset_n = 1'b1;
    sdr_rdy = 1'b1; sdr_data = 32'hABCDEF01;
    tick();
    sdr_rdy = 1'b0;
    chk("rst_after_sdr_req", sdr_req, 0);
    chk("rst_after_rdy", layer_rdy, 0);
    for (int n = 0; n < 3; n++) chk($sformatf("rst_after_data%0d", n), layer_data[n], 0);
    tick();
    chk("rst_after2_rdy", layer_rdy, 0);
    chk("rst_after2_sdr_req", sdr_req, 0);
    $display("reset mid-fetch sequence done: sdr_req=%b rdy=%b", sdr_req, layer_rdy);

    // Round robin, two rounds with SDRAM latency 3
    for (int r = 0; r < 2; r++) begin
      grants.delete();
      pulses = 0; cnt = 0; prev_req = 1'b0; timed_out = 1'b1; cur_g = 3; sent = 0;
      for (int n = 0; n < 3; n++) layer_addr[n] = 21'(32'h1000 + n * 16 + r * 256);
      layer_req = 3'b111;
      tick();
      layer_req = 3'b000;
      for (int c = 0; c < 60; c++) begin
        tick();
        for (int n = 0; n < 3; n++)
          if (layer_rdy[n]) begin
            pulses++;
            chk($sformatf("rr%0d_data_layer%0d", r, n), layer_data[n], sent);
            chk($sformatf("rr%0d_rdy_layer", r), n, cur_g);
          end
        if (sdr_req && !prev_req) begin
          cur_g = 3;
          for (int n = 0; n < 3; n++)
            if (sdr_addr == BASE + 25'(layer_addr[n])) cur_g = n;
          grants.push_back(cur_g);
        end
        prev_req = sdr_req;
        sdr_rdy = 1'b0;
        if (sdr_req) begin
          cnt++;
          if (cnt == 3) begin
            sdr_rdy = 1'b1;
            sent = $urandom;
            sdr_data = sent;
            cnt = 0;
          end
        end else cnt = 0;
        if (grants.size() == 3 && pulses == 3 && !sdr_req) begin
          timed_out = 1'b0;
          break;
        end
      end
      sdr_rdy = 1'b0;
      chk($sformatf("rr%0d_timeout", r), timed_out, 0);
      chk($sformatf("rr%0d_grant_count", r), grants.size(), 3);
      for (int k = 0; k < 3; k++)
        chk($sformatf("rr%0d_grant%0d", r, k), (k < grants.size()) ? grants[k] : 9, k);
      chk($sformatf("rr%0d_pulses", r), pulses, 3);
      $display("round robin round %0d: %0d grants, %0d pulses", r, grants.size(), pulses);
    end

    // Address sum wraps modulo 2^25
    w_req = 3'b001; w_addr[0] = 21'h000008;
    tick();
    w_req = 3'b000;
    tick();
    chk("wrap_sdr_req", w_sreq, 1);
    chk("wrap_sdr_addr", w_saddr, 25'h0000004);
    $display("wrap: sdr_addr=%h", w_saddr);

    // Randomized run against the behavioural model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_busy = 0; m_stale = 0; m_g = 0; m_last = 2; m_exp_addr = 0; m_rdy = 0;
    for (int n = 0; n < 3; n++) begin
      m_pend[n] = 0; m_addr[n] = 0; m_data[n] = 0;
    end
    wcnt = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 3; n++) begin
        rq[n] = ($urandom_range(0, 5) == 0);
        ra[n] = 21'($urandom);
      end
      rd = $urandom;
      if (sdr_req) begin
        if (wcnt == 0) begin
          rr = 1'b1;
          wcnt = $urandom_range(0, 4);
        end else begin
          rr = 1'b0;
          wcnt--;
        end
      end else rr = ($urandom_range(0, 7) == 0);
      layer_req = rq; layer_addr = ra; sdr_rdy = rr; sdr_data = rd;
      model_edge(rq, ra, rr, rd);
      tick();
      chk($sformatf("rnd%0d_sdr_req", c), sdr_req, m_busy);
      if (m_busy) chk($sformatf("rnd%0d_sdr_addr", c), sdr_addr, m_exp_addr);
      chk($sformatf("rnd%0d_layer_rdy", c), layer_rdy, m_rdy);
      for (int n = 0; n < 3; n++)
        chk($sformatf("rnd%0d_data%0d", c, n), layer_data[n], m_data[n]);
      if (c % 100 == 0)
        $display("random cycle %0d req=%b srdy=%b sdr_req=%b rdy=%b", c, rq, rr, sdr_req, layer_rdy);
    end
    layer_req = '0; sdr_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ga23_tile_fetch.md
GA23_TILE_FETCH -- requirements
Module: ga23_tile_fetch

Interface
REQ-001 SHALL have parameter ROM_BASE, default 25'h0, byte offset of the tile ROM region in SDRAM.
REQ-002 SHALL have parameter NUM_LAYERS, default 3, the number of layer request ports; only the value 3 is supported.
REQ-003 SHALL have clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have layer_req  input  3  per-layer one-cycle fetch strobe (bit n = layer n).
REQ-006 SHALL have layer_addr  input  3x21  per-layer tile-row byte address, sampled with its strobe.
REQ-007 SHALL have layer_data  output  3x32  per-layer last fetched row.
REQ-008 SHALL have layer_rdy  output  3  per-layer one-cycle pulse when layer_data has been updated.
REQ-009 SHALL have sdr_addr  output  25  SDRAM byte address.
REQ-010 SHALL have sdr_req  output  1  SDRAM request, held as a level.
REQ-011 SHALL have sdr_rdy  input  1  one-cycle SDRAM completion pulse.
REQ-012 SHALL have sdr_data  input  32  SDRAM read data, valid in the cycle sdr_rdy is high.

Function
REQ-013 SHALL keep, per layer, a pending flag and a 21-bit address register; layer_req[n] sets pending[n] and loads addr[n] from layer_addr[n].
REQ-014 SHALL let a new layer_req[n] that arrives while pending[n] is set overwrite addr[n] (latest wins); only one fetch results.
REQ-015 SHALL implement the states IDLE and BUSY.
REQ-016 In IDLE with any pending bit set, SHALL grant by round-robin, starting at the layer after the last granted; the last-granted pointer resets to layer 2, so layer 0 wins first.
REQ-017 On grant, SHALL do all of the following: clear pending for the granted layer, record the granted index, drive sdr_addr = ROM_BASE + zero-extended addr, assert sdr_req, and enter BUSY. sdr_req SHALL rise in the cycle after the grant decision.
REQ-018 In BUSY, sdr_req and sdr_addr SHALL be held stable until sdr_rdy.
REQ-019 On sdr_rdy in BUSY, SHALL do all of the following in the same cycle: deassert sdr_req, capture sdr_data into layer_data[granted], pulse layer_rdy[granted] for one cycle, and return to IDLE.
REQ-020 Latency from sdr_rdy to layer_rdy/layer_data SHALL be one cycle (registered).
REQ-021 If layer_req[g] arrives for the in-flight layer g during BUSY, SHALL mark that fetch stale: on its sdr_rdy, layer_data[g] is not written and layer_rdy[g] does not pulse; pending[g] is set, so the new address is issued next.
REQ-022 If layer_req arrives in the same cycle as its grant, SHALL treat the request as landing during BUSY, and REQ-021 applies.
REQ-023 A minimum of one IDLE cycle SHALL separate consecutive sdr_req assertions.
REQ-024 SHALL ignore sdr_rdy in IDLE.
REQ-025 SHALL compute the address sum modulo 2^25 with no saturation.
REQ-026 Layers whose layer_req is never asserted SHALL have no effect on arbitration.

Reset
REQ-027 While reset_n=0, SHALL asynchronously force all of the following: state=IDLE, sdr_req=0, sdr_addr=0, pending=0, stale=0, layer_rdy=0, layer_data=0 for all layers, last-granted=2.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch; an sdr_rdy arriving after reset release while IDLE SHALL be ignored.
REQ-029 SHALL accept layer_req on the first edge after reset_n rises.

Verification
REQ-030 Single fetch: layer_req=3'b001 with addr 21'h012340, ROM_BASE=25'h100000 -> sdr_req=1 with sdr_addr=25'h112340. Return sdr_rdy with sdr_data=32'hDEADBEEF after 5 cycles -> layer_rdy=3'b001 for one cycle, layer_data[0]=32'hDEADBEEF.
REQ-031 Round robin: layer_req=3'b111 in one cycle, SDRAM latency 3 -> grants issued in order 0,1,2. After that, a request on all layers -> the next grant order is 0,1,2 again, with exactly three layer_rdy pulses each round.
REQ-032 Overwrite: layer 1 requests 21'h000100 then 21'h000200 on consecutive cycles while layer 0 is BUSY -> a single layer-1 fetch with sdr_addr low bits 21'h000200.
REQ-033 Stale: layer 2 requests again during its own BUSY -> the first sdr_rdy produces no layer_rdy[2]. A second fetch with the new address follows, and its completion produces one layer_rdy[2] with the second data.
REQ-034 Reset mid-fetch: pull reset_n low during BUSY, release, then pulse sdr_rdy -> sdr_req=0, no layer_rdy, layer_data all 0.
REQ-035 Wrap: ROM_BASE=25'h1FFFFFC, addr 21'h000008 -> sdr_addr=25'h0000004.
